// File: rtl/mfp_adc_max10_sequencer_if.sv
// Avalon-ST command and response streams between the scan sequencer (master)
// and the MAX10 modular ADC core (slave).
interface mfp_adc_max10_sequencer_if;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;

  modport master (
    output ADC_C_Valid,
    output ADC_C_Channel,
    output ADC_C_SOP,
    output ADC_C_EOP,
    input  ADC_C_Ready,
    input  ADC_R_Valid,
    input  ADC_R_Channel,
    input  ADC_R_Data
  );

  modport slave (
    input  ADC_C_Valid,
    input  ADC_C_Channel,
    input  ADC_C_SOP,
    input  ADC_C_EOP,
    output ADC_C_Ready,
    output ADC_R_Valid,
    output ADC_R_Channel,
    output ADC_R_Data
  );
endinterface

// File: rtl/mfp_adc_max10_sequencer.sv
// Scan sequencer for the MAX10 modular ADC: walks a shadowed channel list, one
// outstanding command at a time, and turns each response into a result strobe.
module mfp_adc_max10_sequencer #(
  parameter int SLOT_COUNT = 8,
  parameter int SLOT_WIDTH = 3
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [SLOT_COUNT*5-1:0]   seq_channels,
  input  logic [SLOT_WIDTH-1:0]     seq_last,
  input  logic                      seq_continuous,
  input  logic                      trig_enable,
  input  logic                      irq_enable,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      irq_clear,
  mfp_adc_max10_sequencer_if.master adc,
  input  logic                      ADC_Trigger,
  output logic                      res_valid,
  output logic [SLOT_WIDTH-1:0]     res_slot,
  output logic [11:0]               res_data,
  output logic                      busy,
  output logic                      scan_done,
  output logic                      err_mismatch,
  output logic                      ADC_Interrupt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RSP
  } state_e;

  state_e                state_q, state_d;
  logic [SLOT_WIDTH-1:0] slot_q, slot_d;
  logic [SLOT_WIDTH-1:0] last_q, last_d;
  logic [4:0]            chan_q [SLOT_COUNT];
  logic [4:0]            chan_d [SLOT_COUNT];
  logic                  stop_pending_q, stop_pending_d;
  logic                  res_valid_q, res_valid_d;
  logic [SLOT_WIDTH-1:0] res_slot_q, res_slot_d;
  logic [11:0]           res_data_q, res_data_d;
  logic                  scan_done_q, scan_done_d;
  logic                  err_mismatch_q, err_mismatch_d;
  logic                  irq_pending_q, irq_pending_d;
  logic                  trig_s1_q, trig_s1_d;
  logic                  trig_s2_q, trig_s2_d;
  logic                  trig_prev_q, trig_prev_d;
  logic                  trig_edge_q, trig_edge_d;

  logic                  load_cfg;
  logic                  start_scan;
  logic [4:0]            cur_chan;
  logic                  cmd_valid;
  logic [4:0]            cmd_channel;
  logic                  cmd_sop;
  logic                  cmd_eop;

  assign cur_chan   = chan_q[slot_q];
  assign start_scan = start | (trig_edge_q & trig_enable);

  always_comb begin
    trig_s1_d   = ADC_Trigger;
    trig_s2_d   = trig_s1_q;
    trig_prev_d = trig_s2_q;
    trig_edge_d = trig_s2_q & ~trig_prev_q;
  end

  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    last_d         = last_q;
    chan_d         = chan_q;
    load_cfg       = 1'b0;
    stop_pending_d = stop_pending_q | (stop & (state_q != ST_IDLE));
    res_valid_d    = 1'b0;
    res_slot_d     = '0;
    res_data_d     = '0;
    scan_done_d    = 1'b0;
    err_mismatch_d = err_mismatch_q;
    // scan_done_q is fed back so the interrupt rises one cycle after scan_done
    irq_pending_d  = (irq_pending_q & ~irq_clear) | scan_done_q;
    cmd_valid      = 1'b0;
    cmd_channel    = '0;
    cmd_sop        = 1'b0;
    cmd_eop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_scan) begin
          load_cfg = 1'b1;
          slot_d   = '0;
          state_d  = ST_CMD;
        end
      end

      ST_CMD: begin
        // a stop withdraws the command in the same cycle so no half-issued command remains
        if (stop | stop_pending_q) begin
          state_d = ST_IDLE;
        end else begin
          cmd_valid   = 1'b1;
          cmd_channel = cur_chan;
          cmd_sop     = (slot_q == '0);
          cmd_eop     = (slot_q == last_q);
          if (adc.ADC_C_Ready) begin
            state_d = ST_RSP;
          end
        end
      end

      ST_RSP: begin
        if (adc.ADC_R_Valid) begin
          res_valid_d = 1'b1;
          res_slot_d  = slot_q;
          res_data_d  = adc.ADC_R_Data;
          if (adc.ADC_R_Channel != cur_chan) begin
            err_mismatch_d = 1'b1;
          end
          if (slot_q == last_q) begin
            scan_done_d = 1'b1;
            if (seq_continuous && !stop_pending_d) begin
              load_cfg = 1'b1;
              slot_d   = '0;
              state_d  = ST_CMD;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (stop_pending_d) begin
            state_d = ST_IDLE;
          end else begin
            slot_d  = slot_q + SLOT_WIDTH'(1);
            state_d = ST_CMD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // shadow copy: configuration edits mid-scan only apply from the next scan start
    if (load_cfg) begin
      for (int i = 0; i < SLOT_COUNT; i++) begin
        chan_d[i] = seq_channels[5*i +: 5];
      end
      if (int'(seq_last) > SLOT_COUNT - 1) begin
        last_d = SLOT_WIDTH'(SLOT_COUNT - 1);
      end else begin
        last_d = seq_last;
      end
    end

    if (state_d == ST_IDLE) begin
      stop_pending_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= ST_IDLE;
      slot_q         <= '0;
      last_q         <= '0;
      chan_q         <= '{default: '0};
      stop_pending_q <= 1'b0;
      res_valid_q    <= 1'b0;
      res_slot_q     <= '0;
      res_data_q     <= '0;
      scan_done_q    <= 1'b0;
      err_mismatch_q <= 1'b0;
      irq_pending_q  <= 1'b0;
      trig_s1_q      <= 1'b0;
      trig_s2_q      <= 1'b0;
      trig_prev_q    <= 1'b0;
      trig_edge_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      last_q         <= last_d;
      chan_q         <= chan_d;
      stop_pending_q <= stop_pending_d;
      res_valid_q    <= res_valid_d;
      res_slot_q     <= res_slot_d;
      res_data_q     <= res_data_d;
      scan_done_q    <= scan_done_d;
      err_mismatch_q <= err_mismatch_d;
      irq_pending_q  <= irq_pending_d;
      trig_s1_q      <= trig_s1_d;
      trig_s2_q      <= trig_s2_d;
      trig_prev_q    <= trig_prev_d;
      trig_edge_q    <= trig_edge_d;
    end
  end

  assign adc.ADC_C_Valid   = cmd_valid;
  assign adc.ADC_C_Channel = cmd_channel;
  assign adc.ADC_C_SOP     = cmd_sop;
  assign adc.ADC_C_EOP     = cmd_eop;

  assign res_valid     = res_valid_q;
  assign res_slot      = res_slot_q;
  assign res_data      = res_data_q;
  assign busy          = (state_q != ST_IDLE);
  assign scan_done     = scan_done_q;
  assign err_mismatch  = err_mismatch_q;
  assign ADC_Interrupt = irq_pending_q & irq_enable;

endmodule

// File: tb/tb_mfp_adc_max10_sequencer.sv
// Directed bench for the MAX10 ADC scan sequencer: an ADC responder model plus
// a monitor that logs commands and results, checked against hand-computed values.
module tb_mfp_adc_max10_sequencer;
  localparam int SLOT_COUNT = 8;
  localparam int SLOT_WIDTH = 3;

  logic                    HCLK = 1'b0;
  logic                    HRESETn;
  logic [SLOT_COUNT*5-1:0] seq_channels;
  logic [SLOT_WIDTH-1:0]   seq_last;
  logic                    seq_continuous;
  logic                    trig_enable;
  logic                    irq_enable;
  logic                    start;
  logic                    stop;
  logic                    irq_clear;
  logic                    ADC_Trigger;
  logic                    res_valid;
  logic [SLOT_WIDTH-1:0]   res_slot;
  logic [11:0]             res_data;
  logic                    busy;
  logic                    scan_done;
  logic                    err_mismatch;
  logic                    ADC_Interrupt;

  mfp_adc_max10_sequencer_if adc_if ();

  mfp_adc_max10_sequencer #(
    .SLOT_COUNT(SLOT_COUNT),
    .SLOT_WIDTH(SLOT_WIDTH)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .seq_channels  (seq_channels),
    .seq_last      (seq_last),
    .seq_continuous(seq_continuous),
    .trig_enable   (trig_enable),
    .irq_enable    (irq_enable),
    .start         (start),
    .stop          (stop),
    .irq_clear     (irq_clear),
    .adc           (adc_if),
    .ADC_Trigger   (ADC_Trigger),
    .res_valid     (res_valid),
    .res_slot      (res_slot),
    .res_data      (res_data),
    .busy          (busy),
    .scan_done     (scan_done),
    .err_mismatch  (err_mismatch),
    .ADC_Interrupt (ADC_Interrupt)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // responder controls, written only by the main sequence
  bit          rsp_auto;
  int          rsp_delay;
  bit          force_en;
  logic [4:0]  force_chan;
  logic [11:0] force_data;
  int          stray_req;

  // responder state
  int          rsp_wait;
  int          stray_done;
  logic [4:0]  pend_chan;
  int          pend_slot;

  // monitor logs
  int res_slot_log[$];
  int res_data_log[$];
  int hs_chan_log[$];
  int hs_flag_log[$];
  int done_slot_log[$];

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s_start, input logic s_stop, input logic s_clear);
    start     = s_start;
    stop      = s_stop;
    irq_clear = s_clear;
    tick(1);
    start     = 1'b0;
    stop      = 1'b0;
    irq_clear = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, busy, 1'b0);
  endtask

  function automatic logic [SLOT_COUNT*5-1:0] pack4(input logic [4:0] c0, input logic [4:0] c1,
                                                    input logic [4:0] c2, input logic [4:0] c3);
    logic [SLOT_COUNT*5-1:0] v;
    v        = '0;
    v[4:0]   = c0;
    v[9:5]   = c1;
    v[14:10] = c2;
    v[19:15] = c3;
    return v;
  endfunction

  // ADC model: answers each accepted command rsp_delay cycles later with 0x100+slot
  initial begin : adc_responder
    rsp_wait             = 0;
    stray_done           = 0;
    pend_chan            = '0;
    pend_slot            = 0;
    adc_if.ADC_R_Valid   = 1'b0;
    adc_if.ADC_R_Channel = '0;
    adc_if.ADC_R_Data    = '0;
    forever begin
      @(negedge HCLK);
      adc_if.ADC_R_Valid = 1'b0;
      if (!rsp_auto) rsp_wait = 0;
      if (rsp_wait > 0) begin
        rsp_wait--;
        if (rsp_wait == 0) begin
          adc_if.ADC_R_Valid   = 1'b1;
          adc_if.ADC_R_Channel = force_en ? force_chan : pend_chan;
          adc_if.ADC_R_Data    = force_en ? force_data : 12'(12'h100 + pend_slot);
        end
      end
      if (stray_req != stray_done) begin
        adc_if.ADC_R_Valid   = 1'b1;
        adc_if.ADC_R_Channel = 5'd3;
        adc_if.ADC_R_Data    = 12'h5A5;
        stray_done           = stray_req;
      end
      if (rsp_auto && adc_if.ADC_C_Valid && adc_if.ADC_C_Ready) begin
        pend_chan = adc_if.ADC_C_Channel;
        pend_slot = adc_if.ADC_C_SOP ? 0 : pend_slot + 1;
        rsp_wait  = rsp_delay;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge HCLK);
      if (res_valid) begin
        res_slot_log.push_back(int'(res_slot));
        res_data_log.push_back(int'(res_data));
      end
      if (scan_done) done_slot_log.push_back(int'(res_slot));
      if (adc_if.ADC_C_Valid && adc_if.ADC_C_Ready) begin
        hs_chan_log.push_back(int'(adc_if.ADC_C_Channel));
        hs_flag_log.push_back(int'({adc_if.ADC_C_SOP, adc_if.ADC_C_EOP}));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main_seq
    int br;
    int bh;
    int bd;
    int n;
    int exp_ch[4];

    HRESETn              = 1'b0;
    seq_channels         = '0;
    seq_last             = '0;
    seq_continuous       = 1'b0;
    trig_enable          = 1'b0;
    irq_enable           = 1'b1;
    start                = 1'b0;
    stop                 = 1'b0;
    irq_clear            = 1'b0;
    ADC_Trigger          = 1'b0;
    adc_if.ADC_C_Ready   = 1'b1;
    rsp_auto             = 1'b1;
    rsp_delay            = 5;
    force_en             = 1'b0;
    force_chan           = '0;
    force_data           = '0;
    stray_req            = 0;

    $display("[TB] reset state");
    tick(3);
    checkOutput("reset_c_valid", adc_if.ADC_C_Valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_res_valid", res_valid, 1'b0);
    checkOutput("reset_scan_done", scan_done, 1'b0);
    checkOutput("reset_irq", ADC_Interrupt, 1'b0);
    checkOutput("reset_err", err_mismatch, 1'b0);
    HRESETn = 1'b1;
    tick(2);

    $display("[TB] 4-slot single scan");
    seq_channels = pack4(5'd3, 5'd7, 5'd1, 5'd16);
    seq_last     = 3'd3;
    exp_ch       = '{3, 7, 1, 16};
    br = res_slot_log.size();
    bh = hs_chan_log.size();
    bd = done_slot_log.size();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t1_first_valid", adc_if.ADC_C_Valid, 1'b1);
    checkOutput("t1_first_chan", adc_if.ADC_C_Channel, 5'd3);
    waitIdle("t1_idle_timeout", 200);
    tick(2);
    checkOutput("t1_res_count", res_slot_log.size() - br, 4);
    checkOutput("t1_cmd_count", hs_chan_log.size() - bh, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_res_slot", res_slot_log[br + i], i);
      checkOutput("t1_res_data", res_data_log[br + i], 32'h100 + i);
      checkOutput("t1_cmd_chan", hs_chan_log[bh + i], exp_ch[i]);
      checkOutput("t1_cmd_sop_eop", hs_flag_log[bh + i], {30'd0, (i == 0), (i == 3)});
    end
    checkOutput("t1_done_count", done_slot_log.size() - bd, 1);
    checkOutput("t1_done_slot", done_slot_log[bd], 3);
    checkOutput("t1_irq_set", ADC_Interrupt, 1'b1);
    irq_enable = 1'b0;
    #1;
    checkOutput("t1_irq_masked", ADC_Interrupt, 1'b0);
    irq_enable = 1'b1;
    #1;
    checkOutput("t1_irq_unmasked", ADC_Interrupt, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_irq_cleared", ADC_Interrupt, 1'b0);

    $display("[TB] single-slot scan under backpressure");
    seq_channels       = pack4(5'd21, 5'd0, 5'd0, 5'd0);
    seq_last           = 3'd0;
    adc_if.ADC_C_Ready = 1'b0;
    br = res_slot_log.size();
    bh = hs_chan_log.size();
    bd = done_slot_log.size();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t2_cmd_hold",
                  {adc_if.ADC_C_Valid, adc_if.ADC_C_Channel, adc_if.ADC_C_SOP, adc_if.ADC_C_EOP},
                  {1'b1, 5'd21, 1'b1, 1'b1});
      tick(1);
    end
    adc_if.ADC_C_Ready = 1'b1;
    tick(1);
    checkOutput("t2_valid_drop", adc_if.ADC_C_Valid, 1'b0);
    waitIdle("t2_idle_timeout", 50);
    tick(2);
    checkOutput("t2_cmd_count", hs_chan_log.size() - bh, 1);
    checkOutput("t2_res_count", res_slot_log.size() - br, 1);
    checkOutput("t2_res_data", res_data_log[br], 32'h100);
    checkOutput("t2_done_count", done_slot_log.size() - bd, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] continuous scan stopped during slot 0 response");
    seq_channels   = pack4(5'd0, 5'd9, 5'd0, 5'd0);
    seq_last       = 3'd1;
    seq_continuous = 1'b1;
    br = res_slot_log.size();
    bh = hs_chan_log.size();
    bd = done_slot_log.size();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_busy_after_stop", busy, 1'b1);
    waitIdle("t3_idle_timeout", 50);
    tick(8);
    checkOutput("t3_res_count", res_slot_log.size() - br, 1);
    checkOutput("t3_res_slot", res_slot_log[br], 0);
    checkOutput("t3_res_data", res_data_log[br], 32'h100);
    checkOutput("t3_cmd_count", hs_chan_log.size() - bh, 1);
    checkOutput("t3_cmd_chan", hs_chan_log[bh], 0);
    checkOutput("t3_done_count", done_slot_log.size() - bd, 0);
    checkOutput("t3_busy_end", busy, 1'b0);
    checkOutput("t3_irq_quiet", ADC_Interrupt, 1'b0);
    seq_continuous = 1'b0;

    $display("[TB] external trigger");
    seq_channels = pack4(5'd2, 5'd6, 5'd0, 5'd0);
    seq_last     = 3'd1;
    bh = hs_chan_log.size();
    ADC_Trigger = 1'b1;
    tick(2);
    ADC_Trigger = 1'b0;
    tick(8);
    checkOutput("t4_disabled_busy", busy, 1'b0);
    checkOutput("t4_disabled_cmds", hs_chan_log.size() - bh, 0);
    trig_enable = 1'b1;
    br = res_slot_log.size();
    bh = hs_chan_log.size();
    bd = done_slot_log.size();
    ADC_Trigger = 1'b1;
    tick(1);
    ADC_Trigger = 1'b0;
    checkOutput("t4_k0_valid", adc_if.ADC_C_Valid, 1'b0);
    tick(2);
    checkOutput("t4_k2_valid", adc_if.ADC_C_Valid, 1'b0);
    tick(1);
    checkOutput("t4_k3_valid", adc_if.ADC_C_Valid, 1'b1);
    checkOutput("t4_k3_chan", adc_if.ADC_C_Channel, 5'd2);
    tick(3);
    ADC_Trigger = 1'b1;
    tick(2);
    ADC_Trigger = 1'b0;
    waitIdle("t4_idle_timeout", 100);
    tick(8);
    checkOutput("t4_busy_end", busy, 1'b0);
    checkOutput("t4_cmd_count", hs_chan_log.size() - bh, 2);
    checkOutput("t4_res_count", res_slot_log.size() - br, 2);
    checkOutput("t4_done_count", done_slot_log.size() - bd, 1);
    trig_enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] response channel mismatch");
    checkOutput("t5_err_clean", err_mismatch, 1'b0);
    seq_channels = pack4(5'd5, 5'd0, 5'd0, 5'd0);
    seq_last     = 3'd0;
    force_en     = 1'b1;
    force_chan   = 5'd6;
    force_data   = 12'hABC;
    br = res_slot_log.size();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle("t5_idle_timeout", 50);
    tick(2);
    checkOutput("t5_res_count", res_slot_log.size() - br, 1);
    checkOutput("t5_res_data", res_data_log[br], 32'hABC);
    checkOutput("t5_err_set", err_mismatch, 1'b1);
    force_en = 1'b0;
    br = res_slot_log.size();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitIdle("t5_good_idle_timeout", 50);
    tick(2);
    checkOutput("t5_good_res_data", res_data_log[br], 32'h100);
    checkOutput("t5_err_sticky", err_mismatch, 1'b1);

    $display("[TB] reset during slot 2 response");
    seq_channels = pack4(5'd3, 5'd7, 5'd1, 5'd16);
    seq_last     = 3'd3;
    bh = hs_chan_log.size();
    applyStimulus(1'b1, 1'b0, 1'b0);
    n = 0;
    while (hs_chan_log.size() - bh < 3 && n < 100) begin
      tick(1);
      n++;
    end
    checkOutput("t6_reached_slot2", hs_chan_log.size() - bh, 3);
    tick(1);
    rsp_auto = 1'b0;
    HRESETn  = 1'b0;
    #1;
    checkOutput("t6_rst_busy", busy, 1'b0);
    checkOutput("t6_rst_c_valid", adc_if.ADC_C_Valid, 1'b0);
    checkOutput("t6_rst_c_chan", adc_if.ADC_C_Channel, 5'd0);
    checkOutput("t6_rst_res_valid", res_valid, 1'b0);
    checkOutput("t6_rst_irq", ADC_Interrupt, 1'b0);
    checkOutput("t6_rst_err", err_mismatch, 1'b0);
    tick(2);
    HRESETn = 1'b1;
    br = res_slot_log.size();
    stray_req++;
    tick(3);
    checkOutput("t6_stray_ignored", res_slot_log.size() - br, 0);
    checkOutput("t6_stray_busy", busy, 1'b0);
    rsp_auto = 1'b1;
    br = res_slot_log.size();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t6_restart_valid", adc_if.ADC_C_Valid, 1'b1);
    checkOutput("t6_restart_chan", adc_if.ADC_C_Channel, 5'd3);
    checkOutput("t6_restart_sop", adc_if.ADC_C_SOP, 1'b1);
    waitIdle("t6_idle_timeout", 200);
    tick(2);
    checkOutput("t6_restart_res_count", res_slot_log.size() - br, 4);
    checkOutput("t6_restart_first_slot", res_slot_log[br], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
